// File: rtl/seq_pattern_detector.sv
// Flags when the last DEPTH accepted DW-bit symbols equal a runtime-programmable pattern.
// Provides a Mealy flag, a registered Moore flag, overlap control and a saturating match counter.
module seq_pattern_detector #(
    parameter int DW    = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    localparam int FW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DW-1:0]       sym,
    input  logic [DEPTH*DW-1:0] pattern,
    input  logic                overlap,
    output logic                y,
    output logic                z,
    output logic [CNT_W-1:0]    match_cnt,
    output logic                ovf,
    output logic [FW-1:0]       fill
);

    localparam int              HW       = (DEPTH - 1) * DW;
    localparam logic [FW-1:0]   FILL_MAX = FW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [HW-1:0]    hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             y_s;

    // Mealy match: hist already holds symbols 0..DEPTH-2, sym completes the window
    always_comb begin
        y_s = 1'b0;
        if (rst) begin
            y_s = 1'b0;
        end else if (en && (fill_q == FILL_MAX) && ({sym, hist_q} == pattern)) begin
            y_s = 1'b1;
        end else begin
            y_s = 1'b0;
        end
    end

    // Next-state for history, fill level, Moore flag and match statistics
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = y_s;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (en) begin
            for (int k = 0; k < DEPTH - 2; k++) begin
                hist_d[k*DW +: DW] = hist_q[(k+1)*DW +: DW];
            end
            hist_d[(DEPTH-2)*DW +: DW] = sym;
            // Non-overlap restarts the count; overlap keeps the window armed
            if (y_s && !overlap) begin
                fill_d = {FW{1'b0}};
            end else if (fill_q == FILL_MAX) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + FW'(1'b1);
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
        if (y_s) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1'b1);
            end
        end else begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= {HW{1'b0}};
            fill_q <= {FW{1'b0}};
            z_q    <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            ovf_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign y         = y_s;
    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign ovf       = ovf_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Randomised and directed bench for seq_pattern_detector against a queue-based reference model.
module tb_seq_pattern_detector;
    localparam int DW    = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int FW    = $clog2(DEPTH);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [DW-1:0]       sym;
    logic [DEPTH*DW-1:0] pattern;
    logic                overlap;
    logic                y, z, ovf;
    logic [CNT_W-1:0]    match_cnt;
    logic [FW-1:0]       fill;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: accepted symbol history, fresh-symbol count, statistics
    logic [DW-1:0] m_q[$];
    int            m_fresh;
    int            m_cnt;
    bit            m_ovf;
    bit            m_z;

    seq_pattern_detector #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .sym(sym), .pattern(pattern), .overlap(overlap),
        .y(y), .z(z), .match_cnt(match_cnt), .ovf(ovf), .fill(fill)
    );

    always #40 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_y(input logic e, input logic [DW-1:0] s);
        if (!e || m_fresh < DEPTH - 1) return 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (m_q[m_q.size() - (DEPTH - 1) + k] != pattern[k*DW +: DW]) return 1'b0;
        end
        return (s == pattern[(DEPTH-1)*DW +: DW]);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fresh = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_z     = 1'b0;
    endtask

    // Present one cycle of input, check everything against the model, then advance the model
    task automatic step(input logic e, input logic [DW-1:0] s, output bit y_seen);
        bit ye;
        @(negedge clk);
        en  = e;
        sym = s;
        #1;
        ye = model_y(e, s);
        check_eq("y", y, ye);
        check_eq("z", z, m_z);
        check_eq("fill", fill, m_fresh);
        check_eq("match_cnt", match_cnt, m_cnt);
        check_eq("ovf", ovf, m_ovf);
        y_seen = y;
        @(posedge clk);
        m_z = ye;
        if (e) begin
            m_q.push_back(s);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
            if (ye && !overlap) m_fresh = 0;
            else if (m_fresh < DEPTH - 1) m_fresh++;
        end
        if (ye) begin
            if (m_cnt == CMAX) m_ovf = 1'b1;
            else m_cnt++;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            en  = 1'($urandom);
            sym = DW'($urandom);
            #1;
            check_eq("rst_y", y, 0);
            @(negedge clk);
        end
        check_eq("rst_z", z, 0);
        check_eq("rst_cnt", match_cnt, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_fill", fill, 0);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    task automatic run_seq(input logic [DW-1:0] s0, s1, s2, s3, input int gap, output int hits);
        logic [DW-1:0] seq [4];
        bit ys;
        seq = '{s0, s1, s2, s3};
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq[i], ys);
            hits += int'(ys);
            for (int g = 0; g < gap; g++) step(1'b0, DW'($urandom), ys);
        end
    endtask

    initial begin
        bit ys;
        int hits, ph;
        rst = 1'b0; en = 1'b0; sym = '0; pattern = 8'hF4; overlap = 1'b0;
        model_reset();
        #10 rst = 1'b1;

        // 1: reset with random activity, then release
        reset_dut();
        step(1'b0, 2'b00, ys);
        check_eq("post_rst_cnt", match_cnt, 0);

        // 2: basic match 00,01,11,11
        reset_dut();
        pattern = 8'hF4; overlap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] s;
            s = pattern[i*DW +: DW];
            step(1'b1, s, ys);
            check_eq("basic_y_pos", ys, (i == 3));
        end
        step(1'b0, 2'b00, ys);
        check_eq("basic_z", z, 1);
        check_eq("basic_cnt", match_cnt, 1);
        check_eq("basic_fill", fill, 0);

        // 3: overlapping and non-overlapping runs of 01
        reset_dut();
        pattern = 8'h55; overlap = 1'b1; hits = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'b01, ys);
            check_eq("ovl_y_pos", ys, (i >= 3));
            hits += int'(ys);
        end
        step(1'b0, 2'b00, ys);
        check_eq("ovl_cnt", match_cnt, 5);
        reset_dut();
        overlap = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'b01, ys);
            check_eq("novl_y_pos", ys, (i == 3 || i == 7));
        end
        step(1'b0, 2'b00, ys);
        check_eq("novl_cnt", match_cnt, 2);

        // 4: idle gaps do not break a sequence; a mismatching stream never matches
        reset_dut();
        pattern = 8'hF4;
        run_seq(2'b00, 2'b01, 2'b11, 2'b11, 3, hits);
        check_eq("gap_hits", hits, 1);
        check_eq("gap_cnt", match_cnt, 1);
        reset_dut();
        run_seq(2'b00, 2'b01, 2'b11, 2'b10, 0, hits);
        check_eq("mis_hits", hits, 0);
        step(1'b0, 2'b00, ys);
        check_eq("mis_fill", fill, 3);

        // 5: counter saturation and sticky overflow
        reset_dut();
        pattern = 8'h55; overlap = 1'b0;
        for (int m = 0; m < CMAX; m++) run_seq(2'b01, 2'b01, 2'b01, 2'b01, 0, hits);
        step(1'b0, 2'b00, ys);
        check_eq("sat_cnt", match_cnt, CMAX);
        check_eq("sat_ovf", ovf, 0);
        run_seq(2'b01, 2'b01, 2'b01, 2'b01, 0, hits);
        step(1'b0, 2'b00, ys);
        check_eq("ovf_cnt", match_cnt, CMAX);
        check_eq("ovf_set", ovf, 1);
        run_seq(2'b01, 2'b01, 2'b01, 2'b01, 0, hits);
        run_seq(2'b01, 2'b01, 2'b01, 2'b01, 0, hits);
        step(1'b0, 2'b00, ys);
        check_eq("hold_cnt", match_cnt, CMAX);
        check_eq("hold_ovf", ovf, 1);

        // 6: asynchronous reset mid-pattern discards progress
        reset_dut();
        pattern = 8'hF4;
        step(1'b1, 2'b00, ys);
        step(1'b1, 2'b01, ys);
        step(1'b1, 2'b11, ys);
        @(negedge clk);
        en = 1'b0;
        #5 rst = 1'b1;
        #1;
        check_eq("mid_rst_fill", fill, 0);
        check_eq("mid_rst_y", y, 0);
        #9 rst = 1'b0;
        model_reset();
        step(1'b1, 2'b11, ys);
        check_eq("mid_rst_no_match", ys, 0);
        step(1'b0, 2'b00, ys);
        check_eq("mid_rst_cnt", match_cnt, 0);

        // Randomised phase: biased toward the pattern, with pattern/overlap changes on the fly
        reset_dut();
        ph = 0;
        for (int i = 0; i < 600; i++) begin
            logic          e;
            logic [DW-1:0] s;
            if ($urandom_range(0, 49) == 0) pattern = (DEPTH*DW)'($urandom);
            if ($urandom_range(0, 39) == 0) overlap = ~overlap;
            e = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 4) == 0) ? DW'($urandom) : pattern[(ph % DEPTH)*DW +: DW];
            if (e) ph++;
            step(e, s, ys);
        end
        step(1'b0, 2'b00, ys);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
